// File: rtl/vga_sync_decoder_if.sv
// vga_sync_decoder_if -- sync inputs and recovered-timing outputs of the VGA sync decoder.
//   master : sync source / timing consumer (drives hsync_in, vsync_in; observes the rest)
//   slave  : the decoder (samples hsync_in, vsync_in; drives counts, flags, error report)
//   hsync_in, vsync_in : active-high sync pulses
//   rx_hcount, rx_vcount : recovered pixel / line index (10 bits)
//   rx_display_area    : recovered active-video flag
//   locked             : timing verified
//   frame_start        : one-cycle pulse per vsync rising edge
//   sync_error         : one-cycle pulse per detected violation
//   error_code         : cause of the most recent sync_error
interface vga_sync_decoder_if;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned ERR_W = 3;

  logic             hsync_in;
  logic             vsync_in;
  logic [CNT_W-1:0] rx_hcount;
  logic [CNT_W-1:0] rx_vcount;
  logic             rx_display_area;
  logic             locked;
  logic             frame_start;
  logic             sync_error;
  logic [ERR_W-1:0] error_code;

  modport master (
    output hsync_in,
    output vsync_in,
    input  rx_hcount,
    input  rx_vcount,
    input  rx_display_area,
    input  locked,
    input  frame_start,
    input  sync_error,
    input  error_code
  );

  modport slave (
    input  hsync_in,
    input  vsync_in,
    output rx_hcount,
    output rx_vcount,
    output rx_display_area,
    output locked,
    output frame_start,
    output sync_error,
    output error_code
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder -- recovers pixel/line counters from incoming VGA sync pulses,
// verifies line/frame geometry and declares lock after LOCK_FRAMES good frames.
//   clock_25mhz : sole clock, rising edge
//   reset_sync  : synchronous active-high reset
//   sync_bus    : vga_sync_decoder_if.slave (hsync_in/vsync_in in; counts, display
//                 flag, locked, frame_start, sync_error, error_code out, all registered)
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_START     = 144,
  parameter int unsigned H_END       = 784,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_START     = 35,
  parameter int unsigned V_END       = 515,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic              clock_25mhz,
  input  logic              reset_sync,
  vga_sync_decoder_if.slave sync_bus
);

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned CMP_W  = CNT_W + 1;
  localparam int unsigned ERR_W  = 3;
  localparam int unsigned GOOD_W = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_LAST = CNT_W'(H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] VS_LAST = CNT_W'(V_SYNC - 1);

  // Window bounds carry one extra bit so an END of 1024 still compares correctly.
  localparam logic [CMP_W-1:0] H_LO = CMP_W'(H_START);
  localparam logic [CMP_W-1:0] H_HI = CMP_W'(H_END);
  localparam logic [CMP_W-1:0] V_LO = CMP_W'(V_START);
  localparam logic [CMP_W-1:0] V_HI = CMP_W'(V_END);

  localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_FRAMES);

  localparam logic [1:0] ST_SEARCH = 2'b00;
  localparam logic [1:0] ST_VERIFY = 2'b01;
  localparam logic [1:0] ST_LOCKED = 2'b10;

  localparam logic [ERR_W-1:0] ERR_NONE        = ERR_W'(0);
  localparam logic [ERR_W-1:0] ERR_LINE_LEN    = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_HSYNC_WIDTH = ERR_W'(2);
  localparam logic [ERR_W-1:0] ERR_FRAME_LEN   = ERR_W'(3);
  localparam logic [ERR_W-1:0] ERR_VSYNC_WIDTH = ERR_W'(4);
  localparam logic [ERR_W-1:0] ERR_TIMEOUT     = ERR_W'(5);

  logic              h_prev;
  logic              v_prev;
  logic [CNT_W-1:0]  hcount_q;
  logic [CNT_W-1:0]  vcount_q;
  logic [1:0]        state_q;
  logic [GOOD_W-1:0] good_cnt_q;
  logic              locked_q;
  logic              display_q;
  logic              frame_start_q;
  logic              sync_error_q;
  logic [ERR_W-1:0]  error_code_q;

  logic              h_rise;
  logic              h_fall;
  logic              v_rise;
  logic              v_fall;
  logic [CNT_W-1:0]  hcount_d;
  logic [CNT_W-1:0]  vcount_d;
  logic              chk_fail;
  logic [ERR_W-1:0]  chk_code;
  logic [1:0]        state_d;
  logic [GOOD_W-1:0] good_cnt_d;
  logic [GOOD_W-1:0] good_cnt_inc;
  logic              locked_d;
  logic              display_d;
  logic              sync_error_d;
  logic [ERR_W-1:0]  error_code_d;

  // Sync edge detection; vertical edges only count at a line start so that
  // vsync is always judged against a whole number of lines.
  always_comb begin
    h_rise = sync_bus.hsync_in & ~h_prev;
    h_fall = ~sync_bus.hsync_in & h_prev;
    v_rise = h_rise & sync_bus.vsync_in & ~v_prev;
    v_fall = h_rise & ~sync_bus.vsync_in & v_prev;
  end

  // Recovered counters: hcount restarts on every line start, vcount on frame start.
  always_comb begin
    hcount_d = (hcount_q == CNT_SAT) ? CNT_SAT : hcount_q + CNT_W'(1);
    vcount_d = vcount_q;
    if (h_rise) begin
      hcount_d = '0;
      if (v_rise) begin
        vcount_d = '0;
      end else if (vcount_q != CNT_SAT) begin
        vcount_d = vcount_q + CNT_W'(1);
      end
    end
  end

  // Geometry checks against the counts as they stood before this edge;
  // the lowest-numbered cause wins when several fire together.
  always_comb begin
    chk_code = ERR_NONE;
    if (h_rise && (hcount_q != H_LAST)) begin
      chk_code = ERR_LINE_LEN;
    end else if (h_fall && (hcount_q != HS_LAST)) begin
      chk_code = ERR_HSYNC_WIDTH;
    end else if (v_rise && (vcount_q != V_LAST)) begin
      chk_code = ERR_FRAME_LEN;
    end else if (v_fall && (vcount_q != VS_LAST)) begin
      chk_code = ERR_VSYNC_WIDTH;
    end else if ((hcount_q == CNT_SAT) || (vcount_q == CNT_SAT)) begin
      chk_code = ERR_TIMEOUT;
    end
    chk_fail = (chk_code != ERR_NONE);
  end

  // Lock FSM next state plus next values of the registered status outputs.
  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    good_cnt_inc = good_cnt_q + GOOD_W'(1);
    sync_error_d = 1'b0;
    error_code_d = error_code_q;

    case (state_q)
      ST_SEARCH: begin
        if (v_rise) begin
          state_d    = ST_VERIFY;
          good_cnt_d = '0;
        end
      end
      ST_VERIFY: begin
        if (chk_fail) begin
          state_d      = ST_SEARCH;
          good_cnt_d   = '0;
          sync_error_d = 1'b1;
          error_code_d = chk_code;
        end else if (v_rise) begin
          good_cnt_d = good_cnt_inc;
          if (good_cnt_inc >= GOOD_TARGET) begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (chk_fail) begin
          state_d      = ST_SEARCH;
          good_cnt_d   = '0;
          sync_error_d = 1'b1;
          error_code_d = chk_code;
        end
      end
      default: begin
        state_d    = ST_SEARCH;
        good_cnt_d = '0;
      end
    endcase

    // Display flag is built from next-cycle values so it stays registered yet
    // always agrees with the locked/count outputs of the same cycle.
    locked_d  = (state_d == ST_LOCKED);
    display_d = locked_d
              & ({1'b0, hcount_d} >= H_LO) & ({1'b0, hcount_d} < H_HI)
              & ({1'b0, vcount_d} >= V_LO) & ({1'b0, vcount_d} < V_HI);
  end

  // FSM state register.
  always_ff @(posedge clock_25mhz) begin
    if (reset_sync) begin
      state_q    <= ST_SEARCH;
      good_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
    end
  end

  // Sync history, counters and output registers.
  always_ff @(posedge clock_25mhz) begin
    if (reset_sync) begin
      h_prev        <= 1'b0;
      v_prev        <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      locked_q      <= 1'b0;
      display_q     <= 1'b0;
      frame_start_q <= 1'b0;
      sync_error_q  <= 1'b0;
      error_code_q  <= ERR_NONE;
    end else begin
      h_prev        <= sync_bus.hsync_in;
      v_prev        <= sync_bus.vsync_in;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      locked_q      <= locked_d;
      display_q     <= display_d;
      frame_start_q <= v_rise;
      sync_error_q  <= sync_error_d;
      error_code_q  <= error_code_d;
    end
  end

  assign sync_bus.rx_hcount       = hcount_q;
  assign sync_bus.rx_vcount       = vcount_q;
  assign sync_bus.rx_display_area = display_q;
  assign sync_bus.locked          = locked_q;
  assign sync_bus.frame_start     = frame_start_q;
  assign sync_bus.sync_error      = sync_error_q;
  assign sync_bus.error_code      = error_code_q;

endmodule
